// File: rtl/pkt_rr_arb_if.sv
// Packet stream bundle for pkt_rr_arb: NUM_SRC byte-wide ingress streams, one merged egress stream.
// The master modport is the arbiter's view; slave is the surrounding sources/sink.
interface pkt_rr_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
);
  logic [NUM_SRC*8-1:0] in_data;
  logic [NUM_SRC-1:0]   in_sop;
  logic [NUM_SRC-1:0]   in_eop;
  logic [NUM_SRC-1:0]   in_vld;
  logic [NUM_SRC-1:0]   in_rdy;
  logic [7:0]           out_data;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_vld;
  logic                 out_rdy;
  logic [SRC_W-1:0]     out_src;
  logic                 err_sticky;

  modport master (
    input  in_data, in_sop, in_eop, in_vld, out_rdy,
    output in_rdy, out_data, out_sop, out_eop, out_vld, out_src, err_sticky
  );

  modport slave (
    output in_data, in_sop, in_eop, in_vld, out_rdy,
    input  in_rdy, out_data, out_sop, out_eop, out_vld, out_src, err_sticky
  );
endinterface

// File: rtl/pkt_rr_arb.sv
// Packet-atomic round-robin arbiter with a registered output stage.
// Optional stall timeout with forced eop injection: define PKT_ARB_TIMEOUT_EN.
module pkt_rr_arb #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  pkt_rr_arb_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg;
  logic [SRC_W-1:0] gnt_reg;
  logic [SRC_W-1:0] rr_ptr_reg;
  logic             first_reg;
  logic [7:0]       out_data_reg;
  logic             out_sop_reg;
  logic             out_eop_reg;
  logic             out_vld_reg;
  logic [SRC_W-1:0] out_src_reg;
  logic             err_reg;

  logic               load_en;
  logic               accept;
  logic               tmo_fire;
  logic               gnt_vld;
  logic               gnt_sop;
  logic               gnt_eop;
  logic [7:0]         gnt_data;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] drain;
  logic [NUM_SRC-1:0] rdy_vec;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   winner_next;

  assign load_en  = !out_vld_reg || bus.out_rdy;
  assign gnt_vld  = bus.in_vld[gnt_reg];
  assign gnt_sop  = bus.in_sop[gnt_reg];
  assign gnt_eop  = bus.in_eop[gnt_reg];
  assign gnt_data = bus.in_data[8*gnt_reg +: 8];
  assign accept   = (state_reg == BUSY) && load_en && gnt_vld && !tmo_fire;

  // Stray non-sop beats are swallowed while idle; sop beats wait for arbitration.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign req[gi]     = bus.in_vld[gi] & bus.in_sop[gi];
    assign drain[gi]   = bus.in_vld[gi] & ~bus.in_sop[gi];
    assign rdy_vec[gi] = (state_reg == IDLE) ? drain[gi]
                       : ((gnt_reg == SRC_W'(gi)) && load_en && !tmo_fire);
  end
  assign bus.in_rdy = rdy_vec;

  // Scan downward so the candidate closest to rr_ptr is the last to be written.
  always_comb begin : p_winner
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) winner = SRC_W'(idx);
    end
  end

  assign winner_next = (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;

`ifdef PKT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] stall_cnt_reg;

  assign tmo_fire = (state_reg == BUSY) && (stall_cnt_reg == TMO_W'(TIMEOUT)) && load_en;

  // Counts only consecutive idle cycles of the owner; saturates until the release can be emitted.
  always_ff @(posedge clk) begin
    if (rst || state_reg != BUSY || gnt_vld) begin
      stall_cnt_reg <= '0;
    end else if (stall_cnt_reg != TMO_W'(TIMEOUT)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      rr_ptr_reg   <= '0;
      first_reg    <= 1'b0;
      out_data_reg <= '0;
      out_sop_reg  <= 1'b0;
      out_eop_reg  <= 1'b0;
      out_vld_reg  <= 1'b0;
      out_src_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (load_en) begin
        if (accept) begin
          out_vld_reg  <= 1'b1;
          out_data_reg <= gnt_data;
          out_sop_reg  <= gnt_sop;
          out_eop_reg  <= gnt_eop;
          out_src_reg  <= gnt_reg;
        end else if (tmo_fire) begin
          out_vld_reg  <= 1'b1;
          out_data_reg <= 8'h00;
          out_sop_reg  <= 1'b0;
          out_eop_reg  <= 1'b1;
          out_src_reg  <= gnt_reg;
        end else begin
          out_vld_reg  <= 1'b0;
        end
      end

      case (state_reg)
        IDLE: begin
          if (|drain) err_reg <= 1'b1;
          if (|req) begin
            gnt_reg    <= winner;
            rr_ptr_reg <= winner_next;
            first_reg  <= 1'b1;
            state_reg  <= BUSY;
          end
        end
        BUSY: begin
          if (tmo_fire) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else if (accept) begin
            first_reg <= 1'b0;
            if (gnt_sop && !first_reg) err_reg <= 1'b1;
            if (gnt_eop) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_data   = out_data_reg;
  assign bus.out_sop    = out_sop_reg;
  assign bus.out_eop    = out_eop_reg;
  assign bus.out_vld    = out_vld_reg;
  assign bus.out_src    = out_src_reg;
  assign bus.err_sticky = err_reg;
endmodule

// File: tb/tb_pkt_rr_arb.sv
// Randomized and directed bench for pkt_rr_arb, checked every cycle against an owner/pointer model.
module tb_pkt_rr_arb;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_rr_arb_if #(.NUM_SRC(N), .SRC_W(SW)) bus ();
  pkt_rr_arb #(.NUM_SRC(N), .SRC_W(SW), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [7:0] data; logic sop; logic eop; } beat_t;
  typedef struct { logic [7:0] data; logic sop; logic eop; int src; int cyc; } obeat_t;

  beat_t  srcq [N][$];
  obeat_t cap [$];
  bit     rdy_pat [$];
  bit [N-1:0] held;
  int vld_pct, rdy_pct;
  int n_pass, n_total, cyc, rdy1_cnt;
  bit saw_drain2;

  // Reference model: who owns the output, where the round-robin scan starts, what the output register holds.
  int         m_owner, m_ptr, m_src;
  bit         m_first, m_vld, m_sop, m_eop, m_err;
  logic [7:0] m_data;
  bit         p_stall;
  logic [7:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_src = 0; m_first = 0;
    m_vld = 0; m_sop = 0; m_eop = 0; m_err = 0; m_data = '0;
    p_stall = 0;
  endtask

  task automatic push(input int s, input logic [7:0] d, input bit sop, input bit eop);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop;
    srcq[s].push_back(b);
  endtask

  task automatic push_pkt(input int s, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) push(s, base + 8'(k), k == 0, k == len - 1);
  endtask

  task automatic drive(input logic [N-1:0] acc);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        b = srcq[i].pop_front();
        held[i] = 1'b0;
      end
      if (!held[i] && srcq[i].size() > 0 && $urandom_range(0, 99) < vld_pct) held[i] = 1'b1;
      if (held[i]) begin
        b = srcq[i][0];
        bus.in_vld[i] = 1'b1;
        bus.in_data[8*i +: 8] = b.data;
        bus.in_sop[i] = b.sop;
        bus.in_eop[i] = b.eop;
      end else begin
        bus.in_vld[i] = 1'b0;
        bus.in_data[8*i +: 8] = 8'($urandom);
        bus.in_sop[i] = 1'($urandom);
        bus.in_eop[i] = 1'($urandom);
      end
    end
    if (rdy_pat.size() > 0) bus.out_rdy = rdy_pat.pop_front();
    else bus.out_rdy = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // One clock: compare at negedge, advance the model, then let the sources react after posedge.
  task automatic step();
    logic [N-1:0] er, acc_dut;
    bit load, acc;
    int w, idx;
    @(negedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      load = !m_vld || bus.out_rdy;
      er = '0;
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) er[i] = bus.in_vld[i] && !bus.in_sop[i];
      end else begin
        er[m_owner] = load;
      end
      chk("in_rdy", bus.in_rdy, er);
      chk("out_vld", bus.out_vld, m_vld);
      if (m_vld) begin
        chk("out_data", bus.out_data, m_data);
        chk("out_sop", bus.out_sop, m_sop);
        chk("out_eop", bus.out_eop, m_eop);
        chk("out_src", bus.out_src, m_src);
      end
      chk("err_sticky", bus.err_sticky, m_err);
      if (p_stall) chk("stall_stable", bus.out_data, p_data);
      p_stall = bus.out_vld && !bus.out_rdy;
      p_data  = bus.out_data;
      if (bus.out_vld && bus.out_rdy) begin
        obeat_t o;
        o.data = bus.out_data; o.sop = bus.out_sop; o.eop = bus.out_eop;
        o.src = int'(bus.out_src); o.cyc = cyc;
        cap.push_back(o);
        $display("beat cyc=%0d src=%0d data=%02h sop=%0b eop=%0b err=%0b",
                 cyc, o.src, o.data, o.sop, o.eop, bus.err_sticky);
      end
      if (bus.in_rdy[1]) rdy1_cnt++;
      if (bus.in_rdy[2] && bus.in_vld[2] && !bus.in_sop[2]) saw_drain2 = 1'b1;

      acc = (m_owner >= 0) && load && bus.in_vld[m_owner];
      if (load) begin
        if (acc) begin
          m_vld = 1; m_data = bus.in_data[8*m_owner +: 8];
          m_sop = bus.in_sop[m_owner]; m_eop = bus.in_eop[m_owner]; m_src = m_owner;
        end else begin
          m_vld = 0;
        end
      end
      if (m_owner < 0) begin
        if (|er) m_err = 1;
        w = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && bus.in_vld[idx] && bus.in_sop[idx]) w = idx;
        end
        if (w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % N; m_first = 1;
        end
      end else if (acc) begin
        if (bus.in_sop[m_owner] && !m_first) m_err = 1;
        m_first = 0;
        if (bus.in_eop[m_owner]) m_owner = -1;
      end
    end
    acc_dut = bus.in_vld & bus.in_rdy;
    @(posedge clk);
    #1;
    drive(acc_dut);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) srcq[i].delete();
    held = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    drive('0);
    step();
    rst = 1'b0;
    cap.delete();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (cap.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("beat_count", cap.size(), n);
    repeat (3) step();
  endtask

  initial begin
    int total, len, c;
    n_pass = 0; n_total = 0; cyc = 0; rdy1_cnt = 0; saw_drain2 = 0;
    vld_pct = 100; rdy_pct = 100; held = '0;
    bus.in_vld = '0; bus.in_sop = '0; bus.in_eop = '0; bus.in_data = '0; bus.out_rdy = 1'b1;
    model_reset();

    // Reset state, pinned by literals.
    do_reset();
    #1;
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_err", bus.err_sticky, 0);
    chk("rst_in_rdy", bus.in_rdy, 0);

    // Three-beat packet from source 1.
    rdy1_cnt = 0;
    push(1, 8'hA1, 1, 0); push(1, 8'hA2, 0, 0); push(1, 8'hA3, 0, 1);
    run_until(3, 40);
    if (cap.size() == 3) begin
      chk("t1_d0", cap[0].data, 8'hA1);
      chk("t1_d1", cap[1].data, 8'hA2);
      chk("t1_d2", cap[2].data, 8'hA3);
      chk("t1_sop", {cap[0].sop, cap[1].sop, cap[2].sop}, 3'b100);
      chk("t1_eop", {cap[0].eop, cap[1].eop, cap[2].eop}, 3'b001);
      chk("t1_src", cap[0].src, 1);
      chk("t1_back2back", cap[2].cyc - cap[0].cyc, 2);
    end
    chk("t1_rdy1_cycles", rdy1_cnt, 3);

    // Pointer now sits at 2: simultaneous single-beat requests from 0,1,2 go 2,0,1.
    cap.delete();
    push(0, 8'h10, 1, 1); push(1, 8'h11, 1, 1); push(2, 8'h12, 1, 1);
    run_until(3, 40);
    if (cap.size() == 3) begin
      chk("ptr_order0", cap[0].src, 2);
      chk("ptr_order1", cap[1].src, 0);
      chk("ptr_order2", cap[2].src, 1);
    end

    // All sources saturate with 2-beat packets.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) push_pkt(s, 2, 8'(16*s + 4*p));
    run_until(16, 100);
    if (cap.size() == 16) begin
      for (int p = 0; p < 8; p++) begin
        chk("rr_src", cap[2*p].src, p % N);
        if (p > 0) chk("rr_bubble", cap[2*p].cyc - cap[2*p-1].cyc, 2);
      end
    end

    // Backpressure with out_rdy pattern 1,0,0.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0);
    end
    push_pkt(0, 4, 8'h40);
    run_until(4, 80);
    rdy_pat.delete();
    if (cap.size() == 4)
      for (int k = 0; k < 4; k++) chk("bp_data", cap[k].data, 8'h40 + 8'(k));

    // Randomized traffic, valid and ready gaps.
    do_reset();
    vld_pct = 70; rdy_pct = 70; total = 0;
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 6; p++) begin
        len = $urandom_range(1, 5);
        push_pkt(s, len, 8'($urandom));
        total += len;
      end
    run_until(total, 4000);
    vld_pct = 100; rdy_pct = 100;

    // Reset while the second beat of a 5-beat packet is presented.
    do_reset();
    push_pkt(0, 5, 8'h50);
    c = 0;
    while (srcq[0].size() > 4 && c < 20) begin
      step();
      c++;
    end
    chk("rstmid_reached", srcq[0].size(), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_sources();
    drive('0);
    #1;
    chk("rstmid_out_vld", bus.out_vld, 0);
    chk("rstmid_in_rdy", bus.in_rdy, 0);
    cap.delete();
    push_pkt(3, 2, 8'h30);
    run_until(2, 30);
    if (cap.size() == 2) begin
      chk("rstmid_src3", cap[0].src, 3);
      chk("rstmid_sop", cap[0].sop, 1);
    end

    // Stray beat while idle is drained.
    do_reset();
    saw_drain2 = 0;
    push(2, 8'h22, 0, 0);
    repeat (5) step();
    chk("drain_rdy", saw_drain2, 1);
    chk("drain_err", bus.err_sticky, 1);
    chk("drain_no_out", cap.size(), 0);
    chk("drain_consumed", srcq[2].size(), 0);

    // Mid-packet sop is forwarded and flagged.
    do_reset();
    push(1, 8'h61, 1, 0); push(1, 8'h62, 1, 0); push(1, 8'h63, 0, 1);
    run_until(3, 40);
    if (cap.size() == 3) chk("midsop_fwd", cap[1].sop, 1);
    chk("midsop_err", bus.err_sticky, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
